// File: rtl/tcp_rt_timer_engine.sv
// Per-flow retransmission timers and duplicate-ACK detection that feed
// retransmit requests (RTO or fast retransmit) back to the TX engine.
module tcp_rt_timer_engine #(
    parameter int MAX_FLOWS         = 8,
    parameter int FLOWID_W          = $clog2(MAX_FLOWS),
    parameter int TIMESTAMP_W       = 64,
    parameter int ACK_NUM_W         = 32,
    parameter int DUP_ACK_CNT_W     = 4,
    parameter int DUP_ACK_RT        = 3,
    parameter int RT_TIMEOUT_CYCLES = 250000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   arm_val,
    input  logic [FLOWID_W-1:0]    arm_flowid,
    output logic                   arm_rdy,
    input  logic                   ack_val,
    input  logic [FLOWID_W-1:0]    ack_flowid,
    input  logic [ACK_NUM_W-1:0]   ack_num,
    input  logic                   ack_all_acked,
    output logic                   ack_rdy,
    output logic                   rt_req_val,
    output logic [FLOWID_W-1:0]    rt_req_flowid,
    output logic                   rt_req_cause,
    input  logic                   rt_req_rdy,
    output logic [TIMESTAMP_W-1:0] cur_time
);
    localparam logic [TIMESTAMP_W-1:0]   RTO       = TIMESTAMP_W'(RT_TIMEOUT_CYCLES);
    localparam logic [DUP_ACK_CNT_W-1:0] DUP_RT    = DUP_ACK_CNT_W'(DUP_ACK_RT);
    localparam logic [DUP_ACK_CNT_W-1:0] DUP_MAX   = '1;
    localparam logic [FLOWID_W-1:0]      LAST_FLOW = FLOWID_W'(MAX_FLOWS - 1);

    logic [TIMESTAMP_W-1:0]   deadline [MAX_FLOWS];
    logic [ACK_NUM_W-1:0]     last_ack [MAX_FLOWS];
    logic [DUP_ACK_CNT_W-1:0] dup_cnt  [MAX_FLOWS];
    logic [MAX_FLOWS-1:0]     armed;
    logic [MAX_FLOWS-1:0]     fast_pend;
    logic [FLOWID_W-1:0]      scan;

    logic                     ack_new;
    logic                     arm_post_armed;
    logic                     scan_fast;
    logic                     eligible;
    logic                     out_free;
    logic                     load;
    logic [DUP_ACK_CNT_W-1:0] dup_next;
    logic [TIMESTAMP_W-1:0]   restart_dl;

    assign arm_rdy    = 1'b1;
    assign ack_rdy    = 1'b1;
    assign restart_dl = cur_time + RTO;
    assign ack_new    = ack_num != last_ack[ack_flowid];
    assign dup_next   = (dup_cnt[ack_flowid] == DUP_MAX) ? DUP_MAX
                      : dup_cnt[ack_flowid] + DUP_ACK_CNT_W'(1);

    // Timer state the arm sees after a same-cycle ACK on the same flow
    always_comb begin
        arm_post_armed = armed[arm_flowid];
        if (ack_val && ack_flowid == arm_flowid && (ack_new || ack_all_acked))
            arm_post_armed = !ack_all_acked;
    end

    assign scan_fast = fast_pend[scan];
    assign eligible  = scan_fast || (armed[scan] && cur_time >= deadline[scan]);
    assign out_free  = !rt_req_val || rt_req_rdy;
    assign load      = eligible && out_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_time      <= '0;
            armed         <= '0;
            fast_pend     <= '0;
            scan          <= '0;
            rt_req_val    <= 1'b0;
            rt_req_flowid <= '0;
            rt_req_cause  <= 1'b0;
            for (int i = 0; i < MAX_FLOWS; i++) begin
                deadline[i] <= '0;
                last_ack[i] <= '0;
                dup_cnt[i]  <= '0;
            end
        end else begin
            cur_time <= cur_time + TIMESTAMP_W'(1);

            // Placed first so a same-cycle ACK to this flow overrides it
            if (load && !scan_fast)
                dup_cnt[scan] <= '0;

            if (ack_val) begin
                if (ack_new) begin
                    last_ack[ack_flowid] <= ack_num;
                    dup_cnt[ack_flowid]  <= '0;
                    armed[ack_flowid]    <= !ack_all_acked;
                    if (!ack_all_acked)
                        deadline[ack_flowid] <= restart_dl;
                end else if (!ack_all_acked) begin
                    dup_cnt[ack_flowid] <= dup_next;
                    if (dup_next == DUP_RT)
                        fast_pend[ack_flowid] <= 1'b1;
                end else begin
                    armed[ack_flowid]   <= 1'b0;
                    dup_cnt[ack_flowid] <= '0;
                end
            end

            if (arm_val && !arm_post_armed) begin
                armed[arm_flowid]    <= 1'b1;
                deadline[arm_flowid] <= restart_dl;
            end

            // An issued request's clear overrides any same-cycle update
            if (load) begin
                if (scan_fast)
                    fast_pend[scan] <= 1'b0;
                else
                    armed[scan] <= 1'b0;
                rt_req_val    <= 1'b1;
                rt_req_flowid <= scan;
                rt_req_cause  <= scan_fast;
            end else if (rt_req_rdy) begin
                rt_req_val <= 1'b0;
            end

            if (!eligible || out_free)
                scan <= (scan == LAST_FLOW) ? '0 : scan + FLOWID_W'(1);
        end
    end
endmodule

// File: tb/tb_tcp_rt_timer_engine.sv
// Scoreboard bench for tcp_rt_timer_engine: directed scenarios followed by
// randomized arm/ACK/backpressure traffic against a behavioural model.
module tb_tcp_rt_timer_engine;
    localparam int NF  = 8;
    localparam int FW  = 3;
    localparam int DR  = 3;
    localparam int RTO = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          arm_val = 1'b0;
    logic [FW-1:0] arm_flowid = '0;
    logic          arm_rdy;
    logic          ack_val = 1'b0;
    logic [FW-1:0] ack_flowid = '0;
    logic [31:0]   ack_num = '0;
    logic          ack_all_acked = 1'b0;
    logic          ack_rdy;
    logic          rt_req_val;
    logic [FW-1:0] rt_req_flowid;
    logic          rt_req_cause;
    logic          rt_req_rdy = 1'b1;
    logic [63:0]   cur_time;

    always #5 clk = ~clk;

    tcp_rt_timer_engine #(
        .MAX_FLOWS(NF), .TIMESTAMP_W(64), .ACK_NUM_W(32),
        .DUP_ACK_CNT_W(4), .DUP_ACK_RT(DR), .RT_TIMEOUT_CYCLES(RTO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .arm_val(arm_val), .arm_flowid(arm_flowid), .arm_rdy(arm_rdy),
        .ack_val(ack_val), .ack_flowid(ack_flowid), .ack_num(ack_num),
        .ack_all_acked(ack_all_acked), .ack_rdy(ack_rdy),
        .rt_req_val(rt_req_val), .rt_req_flowid(rt_req_flowid),
        .rt_req_cause(rt_req_cause), .rt_req_rdy(rt_req_rdy),
        .cur_time(cur_time)
    );

    typedef struct packed { logic [FW-1:0] flow; logic cause; } exp_t;
    typedef struct packed { logic [FW-1:0] flow; logic cause; logic [63:0] t; } acc_t;

    exp_t exp_q[$];
    acc_t acc_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // Behavioural reference state
    logic [63:0] m_dl   [NF];
    logic [31:0] m_last [NF];
    int          m_dup  [NF];
    bit          m_arm  [NF];
    bit          m_fp   [NF];
    int          m_scan;
    bit          m_val;
    logic [63:0] m_time;

    function automatic void chk(string nm, logic [63:0] got, logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NF; i++) begin
            m_dl[i] = '0; m_last[i] = '0; m_dup[i] = 0;
            m_arm[i] = 1'b0; m_fp[i] = 1'b0;
        end
        m_scan = 0; m_val = 1'b0; m_time = '0;
        exp_q.delete();
    endtask

    // One clock of the spec's rules: scanner decides on old state,
    // ACK then arm update, and an issued request's clear is final.
    task automatic model_step();
        int s    = m_scan;
        bit fp   = m_fp[s];
        bit elig = fp || (m_arm[s] && m_time >= m_dl[s]);
        bit fire = elig && (!m_val || rt_req_rdy);
        int f    = int'(ack_flowid);
        int g    = int'(arm_flowid);
        if (ack_val) begin
            if (ack_num != m_last[f]) begin
                m_last[f] = ack_num;
                m_dup[f]  = 0;
                m_arm[f]  = !ack_all_acked;
                if (!ack_all_acked) m_dl[f] = m_time + 64'(RTO);
            end else if (!ack_all_acked) begin
                m_dup[f] = (m_dup[f] >= 15) ? 15 : m_dup[f] + 1;
                if (m_dup[f] == DR) m_fp[f] = 1'b1;
            end else begin
                m_arm[f] = 1'b0;
                m_dup[f] = 0;
            end
        end
        if (arm_val && !m_arm[g]) begin
            m_arm[g] = 1'b1;
            m_dl[g]  = m_time + 64'(RTO);
        end
        if (fire) begin
            if (fp) m_fp[s] = 1'b0;
            else begin
                m_arm[s] = 1'b0;
                if (!(ack_val && f == s)) m_dup[s] = 0;
            end
            exp_q.push_back('{flow: FW'(s), cause: fp});
        end
        m_val = fire || (m_val && !rt_req_rdy);
        if (!elig || fire) m_scan = (s + 1) % NF;
        m_time++;
    endtask

    // Monitor: compares DUT output against the scoreboard every cycle
    always @(negedge clk) begin
        n_chk++;
        if (cur_time !== m_time) begin
            n_fail++;
            $display("FAIL cur_time: got %0d want %0d", cur_time, m_time);
        end
        n_chk++;
        if (rt_req_val !== (exp_q.size() != 0)) begin
            n_fail++;
            $display("FAIL rt_req_val @%0d: got %b want %b",
                     m_time, rt_req_val, exp_q.size() != 0);
        end
        if (rt_req_val === 1'b1 && exp_q.size() != 0) begin
            n_chk++;
            if (rt_req_flowid !== exp_q[0].flow || rt_req_cause !== exp_q[0].cause) begin
                n_fail++;
                $display("FAIL rt_req @%0d: got flow %0d cause %0d want flow %0d cause %0d",
                         m_time, rt_req_flowid, rt_req_cause, exp_q[0].flow, exp_q[0].cause);
            end
            if (rt_req_rdy) begin
                acc_q.push_back('{flow: rt_req_flowid, cause: rt_req_cause, t: cur_time});
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #2;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_until(logic [63:0] t);
        while (m_time < t) tick();
    endtask

    task automatic do_arm(int f);
        arm_val = 1'b1; arm_flowid = FW'(f);
        tick();
        arm_val = 1'b0;
    endtask

    task automatic do_ack(int f, logic [31:0] n, bit all);
        ack_val = 1'b1; ack_flowid = FW'(f); ack_num = n; ack_all_acked = all;
        tick();
        ack_val = 1'b0;
    endtask

    function automatic int count_since(int n0, int flow, int cause);
        int c = 0;
        for (int i = n0; i < acc_q.size(); i++)
            if ((flow < 0 || int'(acc_q[i].flow) == flow) &&
                (cause < 0 || int'(acc_q[i].cause) == cause))
                c++;
        return c;
    endfunction

    initial begin
        int n0;
        logic [63:0] t0;
        model_reset();
        idle(3);
        chk("rst_val", 64'(rt_req_val), 0);
        chk("rst_flowid", 64'(rt_req_flowid), 0);
        chk("rst_cause", 64'(rt_req_cause), 0);
        chk("rst_arm_rdy", 64'(arm_rdy), 1);
        chk("rst_ack_rdy", 64'(ack_rdy), 1);
        chk("rst_time", cur_time, 0);
        rst_n = 1'b1;

        // RTO expiry on flow 2
        n0 = acc_q.size();
        wait_until(10);
        do_arm(2);
        wait_until(230);
        chk("t1_count", 64'(count_since(n0, -1, -1)), 1);
        if (acc_q.size() > n0) begin
            chk("t1_flow", 64'(acc_q[n0].flow), 2);
            chk("t1_cause", 64'(acc_q[n0].cause), 0);
            chk("t1_window", 64'(acc_q[n0].t >= 110 && acc_q[n0].t <= 118), 1);
        end

        // Fast retransmit on the third duplicate of flow 5
        n0 = acc_q.size();
        do_ack(5, 1000, 1'b0);
        idle(2);
        do_ack(5, 1000, 1'b0);
        idle(2);
        do_ack(5, 1000, 1'b0);
        idle(2);
        chk("t2_none_early", 64'(count_since(n0, -1, -1)), 0);
        do_ack(5, 1000, 1'b0);
        idle(12);
        chk("t2_fast_one", 64'(count_since(n0, 5, 1)), 1);
        do_ack(5, 1000, 1'b0);
        idle(12);
        chk("t2_fourth_dup", 64'(count_since(n0, -1, -1)), 1);
        do_ack(5, 2000, 1'b1);

        // Full ACK cancels the timer
        n0 = acc_q.size();
        do_arm(0);
        idle(49);
        do_ack(0, 2000, 1'b1);
        idle(300);
        chk("t3_cancel", 64'(count_since(n0, -1, -1)), 0);

        // Backpressure with flows 1 and 3 both expired
        n0 = acc_q.size();
        t0 = m_time;
        do_arm(1);
        idle(7);
        do_arm(3);
        wait_until(t0 + 98);
        rt_req_rdy = 1'b0;
        wait_until(t0 + 125);
        chk("t4_val_held", 64'(rt_req_val), 1);
        chk("t4_flow_held", 64'(rt_req_flowid), 1);
        idle(5);
        chk("t4_flow_stable", 64'(rt_req_flowid), 1);
        rt_req_rdy = 1'b1;
        idle(20);
        chk("t4_count", 64'(count_since(n0, -1, 0)), 2);
        if (acc_q.size() >= n0 + 2) begin
            chk("t4_first", 64'(acc_q[n0].flow), 1);
            chk("t4_second", 64'(acc_q[n0 + 1].flow), 3);
        end

        // Same-cycle ACK (new, all acked) and arm on flow 4
        do_arm(4);
        idle(20);
        n0 = acc_q.size();
        t0 = m_time;
        ack_val = 1'b1; ack_flowid = 3'd4; ack_num = 500; ack_all_acked = 1'b1;
        arm_val = 1'b1; arm_flowid = 3'd4;
        tick();
        ack_val = 1'b0; arm_val = 1'b0;
        wait_until(t0 + 130);
        chk("t5_count", 64'(count_since(n0, 4, 0)), 1);
        if (acc_q.size() > n0)
            chk("t5_window", 64'(acc_q[n0].t >= t0 + 101 && acc_q[n0].t <= t0 + 108), 1);

        // Mid-run reset drops a pending request
        rt_req_rdy = 1'b0;
        do_arm(6);
        do_arm(7);
        idle(115);
        chk("t6_pending", 64'(rt_req_val), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_val", 64'(rt_req_val), 0);
        chk("t6_flowid", 64'(rt_req_flowid), 0);
        chk("t6_cause", 64'(rt_req_cause), 0);
        chk("t6_time", cur_time, 0);
        model_reset();
        idle(2);
        rst_n = 1'b1;
        rt_req_rdy = 1'b1;
        n0 = acc_q.size();
        idle(300);
        chk("t6_quiet", 64'(count_since(n0, -1, -1)), 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            arm_val       = ($urandom_range(0, 7) == 0);
            arm_flowid    = FW'($urandom_range(0, NF - 1));
            ack_val       = ($urandom_range(0, 3) == 0);
            ack_flowid    = FW'($urandom_range(0, NF - 1));
            ack_num       = ($urandom_range(0, 3) != 0) ? m_last[ack_flowid]
                          : 32'($urandom_range(1, 20));
            ack_all_acked = ($urandom_range(0, 4) == 0);
            rt_req_rdy    = ($urandom_range(0, 3) != 0);
            tick();
        end
        arm_val = 1'b0;
        ack_val = 1'b0;
        rt_req_rdy = 1'b1;
        idle(300);
        chk("drain_empty", 64'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tcp_rt_timer_engine.md
# tcp_rt_timer_engine

Per-flow retransmission timer and duplicate-ACK detector for the TCP slow path. It consumes the RX engine's per-segment ACK updates and the TX engine's "segment sent" notifications. It keeps a per-flow `{timestamp, timer_armed}` timer and `{ack_num, dup_ack_cnt}` ACK state, and issues retransmit requests back to the TX engine. A causes are RTO expiry and the third duplicate ACK.

## Interface
- `MAX_FLOWS`, default 8: number of flows tracked.
- `FLOWID_W`, default `$clog2(MAX_FLOWS)`: flow ID width.
- `TIMESTAMP_W`, default 64: free-running time counter width.
- `ACK_NUM_W`, default 32: ACK number width.
- `DUP_ACK_CNT_W`, default 4: duplicate-ACK counter width.
- `DUP_ACK_RT`, default 3: duplicate count that triggers fast retransmit.
- `RT_TIMEOUT_CYCLES`, default 250000000: RTO in cycles (1 s).

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `arm_val` / `arm_flowid` / `arm_rdy`  in / in / out  1 / FLOWID_W / 1  TX sent data on the flow; `arm_rdy` is tied to 1.
- `ack_val` / `ack_flowid` / `ack_num` / `ack_all_acked` / `ack_rdy`  in / in / in / in / out  1 / FLOWID_W / ACK_NUM_W / 1 / 1  RX ACK update; `ack_all_acked` = 1 means there is no outstanding unacked data; `ack_rdy` is tied to 1.
- `rt_req_val` / `rt_req_flowid` / `rt_req_cause` / `rt_req_rdy`  out / out / out / in  1 / FLOWID_W / 1 / 1  retransmit request; cause 0 = RTO, 1 = fast retransmit.
- `cur_time`  out  TIMESTAMP_W  free-running cycle counter.

## Operation
- **Time counter:** `cur_time` increments by 1 every cycle from 0. No wrap handling.
- **Per-flow state:** `deadline[TIMESTAMP_W]`, `armed`, `last_ack[ACK_NUM_W]`, `dup_cnt[DUP_ACK_CNT_W]`, `fast_pend`.
- **Arm** (`arm_val`):
  - If not armed: `armed` ← 1 and `deadline` ← `cur_time + RT_TIMEOUT_CYCLES`.
  - If already armed: state is unchanged.
- **ACK** (`ack_val`), evaluated against the flow's pre-update state:
  - `ack_num != last_ack`: `last_ack` ← `ack_num`, `dup_cnt` ← 0. If `ack_all_acked`, `armed` ← 0; otherwise `armed` ← 1 and `deadline` ← `cur_time + RT_TIMEOUT_CYCLES`.
  - `ack_num == last_ack` with `ack_all_acked = 0`: `dup_cnt` increments, saturating at all-ones. If the incremented value equals `DUP_ACK_RT`, `fast_pend` ← 1. Nothing else changes.
  - `ack_num == last_ack` with `ack_all_acked = 1`: `armed` ← 0 and `dup_cnt` ← 0.
- **Same flow, same cycle, arm and ACK:** apply the ACK, then the arm. The result is armed. If the ACK disarmed or restarted the timer, `deadline` = `cur_time + RT_TIMEOUT_CYCLES`.
- **Scanner:**
  - Pointer `scan` visits one flow per cycle and wraps from `MAX_FLOWS-1` to 0.
  - The visited flow is eligible if `fast_pend`, or if `armed` and `cur_time >= deadline` (unsigned compare).
  - `fast_pend` has priority over RTO for the same flow.
  - If the flow is eligible and the output register is empty:
    - Load the output register.
    - Clear `fast_pend` (cause 1), or clear `armed` and `dup_cnt` (cause 0).
    - Advance `scan`.
  - If the flow is eligible and the output register is full: `scan` holds.
  - If the flow is not eligible: `scan` advances.
  - TX re-arms the timer by issuing an arm when it retransmits.
- **Scanner vs. ACK on the same flow, same cycle:** the scanner decision uses pre-update state, so an issued request stands. The ACK update is applied on top, except that the scanner's clear of `fast_pend` or `armed` wins.
- **Output handshake:** valid/ready. The register is held stable while `rt_req_val && !rt_req_rdy` and is released on a cycle where val and rdy are both high.

## Timing
- **Reset:**
  - `cur_time` = 0, all `armed` = 0, `deadline` = 0, `last_ack` = 0, `dup_cnt` = 0, `fast_pend` = 0, `scan` = 0.
  - `rt_req_val` = 0, `rt_req_flowid` = 0, `rt_req_cause` = 0. `arm_rdy` = `ack_rdy` = 1.
- State updates from arm/ACK take effect on the next edge. The scanner sees them one cycle after the input handshake.
- Scanner visit at cycle t → `rt_req_val` high at t+1.
- Worst-case detection latency after expiry: `MAX_FLOWS` cycles plus output backpressure time.
- A new request can load in the same cycle the previous one is accepted: the register is treated as empty when `rt_req_rdy` is high. This gives one request per cycle sustained.
- Reset asserted mid-operation clears everything asynchronously. A pending request is dropped.

## Test plan
1. **RTO expiry:** `RT_TIMEOUT_CYCLES`=100; arm flow 2 at `cur_time` 10 → request {flow 2, cause 0} no earlier than time 110 and no later than 118; `armed[2]` = 0 afterwards.
2. **Fast retransmit:** ACKs 1000 (new), then 1000, 1000, 1000, all with `ack_all_acked`=0, on flow 5 → exactly one {5, cause 1}, after the third duplicate; a fourth duplicate produces no request.
3. **Full ACK cancels timer:** arm flow 0, then at +50 send ACK 2000 with `ack_all_acked`=1 → no request through time +300.
4. **Backpressure:** flows 1 and 3 expire together with `rt_req_rdy`=0 for 20 cycles → `rt_req_val` stays high with flow 1 stable; after ready, flow 1 then flow 3 are issued, with no loss or duplication.
5. **Simultaneous arm and ACK:** flow 4 armed; same cycle, ACK 500 (new, all acked) plus arm → flow 4 armed with `deadline` = that cycle's `cur_time + 100`.
6. **Mid-run reset:** pending request plus armed flows; pulse `rst_n` low → all outputs at reset values immediately; no request after release.
